fpnew_result_reorder: RTL and testbench
=======================================

Name: fpnew_result_reorder

Overview:
- Parametrised in-order retirement buffer that replaces the round-robin output arbiter behind the operation-group blocks in the FPU top.
- Each issued operation is given a slot ID at issue. Operation groups complete out of order on N channels, tagged with that ID.
- Results leave on one valid/ready output strictly in issue order.
- Adds flush, occupancy reporting and protocol-error detection, which the arbiter lacks.

Parameters:
- NumChannels, 5, number of completion channels (one per operation group); must be ≥1.
- Width, 64, result width in bits.
- Depth, 8, number of in-flight slots; must be a power of two and ≥2.
- TagType, logic, user tag type carried with each result.
- IdxWidth, $clog2(Depth), derived, not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- issue_valid_i  in  1  request to allocate a slot.
- issue_ready_o  out  1  a slot is available.
- issue_id_o  out  IdxWidth  ID allocated on the issue handshake.
- flush_i  in  1  discard all in-flight entries.
- chan_valid_i  in  NumChannels  a completion is presented on that channel.
- chan_ready_o  out  NumChannels  completion accepted; always 1 outside reset.
- chan_id_i  in  NumChannels x IdxWidth  slot ID of each completion.
- chan_result_i  in  NumChannels x Width  result data.
- chan_status_i  in  NumChannels x fpnew_pkg::status_t  exception flags.
- chan_tag_i  in  NumChannels x TagType  user tag.
- out_valid_o  out  1  the head slot is complete.
- out_ready_i  in  1  downstream accepts the result.
- result_o  out  Width  head result.
- status_o  out  status_t  head flags.
- tag_o  out  TagType  head tag.
- level_o  out  IdxWidth+1  number of allocated slots.
- busy_o  out  1  level_o != 0.
- protocol_err_o  out  1  sticky illegal-completion flag.

Behaviour:
- State:
  - Head and tail pointers, each IdxWidth+1 bits; the top bit is the wrap bit.
  - Per slot: alloc bit, done bit, result, status and tag.
  - Empty when head == tail. Full when indices are equal and wrap bits differ.
  - level_o = tail - head, computed modulo 2^(IdxWidth+1).
- Reset (rst_ni=0 at a clock edge):
  - head, tail, all alloc/done bits and protocol_err_o are cleared.
  - Output values during and after reset: issue_ready_o=1 (0 while rst_ni=0), chan_ready_o=0 while in reset, out_valid_o=0, level_o=0, busy_o=0, issue_id_o=0.
  - Slot data storage is not reset.
  - A reset mid-operation discards all entries.
- Issue:
  - issue_ready_o = !full & !flush_i. It depends on registered full only, so a pop in the same cycle does not free a slot for issue.
  - issue_id_o = tail index.
  - On handshake: slot[tail].alloc=1, done=0, tail+1.
- Completion:
  - A channel write is legal if its slot has alloc=1 and done=0.
  - A legal write stores result, status and tag and sets done=1, visible from the next cycle.
  - Illegal writes are dropped and set protocol_err_o=1. Illegal means: target slot not allocated, target slot already done, or more than one channel targeting the same ID in one cycle. In the same-ID case the lowest channel index wins and the rest are dropped.
  - A completion to the slot being issued in the same cycle is illegal, because alloc was 0 beforehand.
- Output:
  - out_valid_o = slot[head].done.
  - result_o, status_o and tag_o come from slot[head], gated to 0 when out_valid_o=0.
  - Minimum latency: a completion in cycle t gives out_valid_o in cycle t+1. There is no bypass.
  - On out_valid_o & out_ready_i: clear alloc/done of the head slot and advance head.
  - Output data stays stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous events:
  - Issue and pop in the same cycle: level is unchanged and both pointers advance.
  - A completion to the head slot while the head is popped cannot occur, because the head is already done; it is flagged as illegal.
- Wrap-around: pointers wrap modulo 2*Depth. IDs reuse indices modulo Depth.
- flush_i, highest priority below reset:
  - Clears all alloc/done bits, sets head=tail=0 and clears protocol_err_o.
  - Issue, completions and pop in that cycle are ignored; out_ready_i has no effect.
  - out_valid_o=0 from the next cycle.

Decomposition:
- fpnew_pkg gains a status_t reuse only. There are no new package types, because the slot struct depends on parameters and stays local (entry_t: result, status, tag).
- Add function fpnew_pkg::rob_level(head, tail) only if shared elsewhere; otherwise keep it local.
- One sub-module is natural: fpnew_rob_wr_decode. It takes per-channel valid and ID, and produces a per-slot write-enable, a winning-channel select (lowest index), and a conflict flag.

Test Plan:
- Reset, issue 3 ops (IDs 0,1,2), complete channel 2 for ID 2, then channel 0 for ID 0, then channel 1 for ID 1, with out_ready_i=1 → outputs in order 0,1,2. Each out_valid_o appears one cycle after the matching completion; level_o returns to 0.
- Depth=8: issue 8 ops → issue_ready_o=0 and level_o=8. Complete and pop ID 0 while issue_valid_i=1 → no issue that cycle; next cycle issue_id_o=0 (wrap), level_o=8.
- Channels 1 and 3 both complete ID 4 in one cycle → channel 1's data retires, protocol_err_o=1. A later completion to an unallocated ID 7 is dropped, and the error stays set.
- Head done, out_ready_i=0 for 5 cycles → result_o, status_o and tag_o stay stable and head does not advance.
- Five in flight, two done; assert flush_i together with issue_valid_i and a completion → next cycle level_o=0, out_valid_o=0, busy_o=0, protocol_err_o=0, issue_id_o=0.
- Assert rst_ni=0 for one cycle with 4 in flight → all outputs return to reset values and the next issue gets ID 0.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU types; only the IEEE exception flag set is needed by the result reorder block.
package fpnew_pkg;
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;
endpackage

// File: rtl/fpnew_result_reorder_pkg.sv
// Types and helpers shared by the result reorder buffer, its write decoder and its interface.
package fpnew_result_reorder_pkg;
    typedef fpnew_pkg::status_t status_t;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fpnew_result_reorder_if.sv
// Issue, completion and retirement bundle of the result reorder buffer.
// slave = reorder buffer side, master = issue logic / op groups / consumer side.
interface fpnew_result_reorder_if #(
    parameter int unsigned NumChannels = 5,
    parameter int unsigned Width       = 64,
    parameter int unsigned Depth       = 8,
    parameter type         TagType     = logic
);
    import fpnew_result_reorder_pkg::*;
    localparam int unsigned IdxWidth = $clog2(Depth);

    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [IdxWidth-1:0]    issue_id_o;
    logic                   flush_i;
    logic [NumChannels-1:0] chan_valid_i;
    logic [NumChannels-1:0] chan_ready_o;
    logic [IdxWidth-1:0]    chan_id_i     [NumChannels];
    logic [Width-1:0]       chan_result_i [NumChannels];
    status_t                chan_status_i [NumChannels];
    TagType                 chan_tag_i    [NumChannels];
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [Width-1:0]       result_o;
    status_t                status_o;
    TagType                 tag_o;
    logic [IdxWidth:0]      level_o;
    logic                   busy_o;
    logic                   protocol_err_o;

    modport slave (
        input  issue_valid_i, flush_i, chan_valid_i, chan_id_i, chan_result_i,
               chan_status_i, chan_tag_i, out_ready_i,
        output issue_ready_o, issue_id_o, chan_ready_o, out_valid_o, result_o,
               status_o, tag_o, level_o, busy_o, protocol_err_o
    );

    modport master (
        output issue_valid_i, flush_i, chan_valid_i, chan_id_i, chan_result_i,
               chan_status_i, chan_tag_i, out_ready_i,
        input  issue_ready_o, issue_id_o, chan_ready_o, out_valid_o, result_o,
               status_o, tag_o, level_o, busy_o, protocol_err_o
    );
endinterface

// File: rtl/fpnew_rob_wr_decode.sv
// Maps per-channel completions onto per-slot write enables; lowest channel wins a shared slot.
// Purely combinational, no backpressure; conflict flags any slot targeted by two or more channels.
module fpnew_rob_wr_decode
    import fpnew_result_reorder_pkg::*;
#(
    parameter int unsigned NumChannels = 5,
    parameter int unsigned Depth       = 8,
    localparam int unsigned IdxWidth   = $clog2(Depth),
    localparam int unsigned SelWidth   = sel_width(NumChannels)
) (
    input  logic [NumChannels-1:0] chan_valid,
    input  logic [IdxWidth-1:0]    chan_id  [NumChannels],
    output logic [Depth-1:0]       slot_we,
    output logic [SelWidth-1:0]    slot_sel [Depth],
    output logic                   conflict
);
    always_comb begin
        slot_we  = '0;
        conflict = 1'b0;
        for (int s = 0; s < Depth; s++) begin
            slot_sel[s] = '0;
            for (int c = 0; c < NumChannels; c++) begin
                if (chan_valid[c] && (chan_id[c] == IdxWidth'(s))) begin
                    if (slot_we[s]) begin
                        conflict = 1'b1;
                    end else begin
                        slot_we[s]  = 1'b1;
                        slot_sel[s] = SelWidth'(c);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/fpnew_result_reorder.sv
// In-order retirement buffer for out-of-order op-group completions; completion to out_valid is one cycle.
// Issue stalls on a registered full flag (a same-cycle pop does not free a slot); output holds while out_ready_i is low.
module fpnew_result_reorder
    import fpnew_result_reorder_pkg::*;
#(
    parameter int unsigned NumChannels = 5,
    parameter int unsigned Width       = 64,
    parameter int unsigned Depth       = 8,
    parameter type         TagType     = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fpnew_result_reorder_if.slave bus
);
    localparam int unsigned IdxWidth = $clog2(Depth);
    localparam int unsigned SelWidth = sel_width(NumChannels);

    typedef logic [IdxWidth:0] ptr_t;
    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        TagType           tag;
    } entry_t;

    ptr_t                head_q, tail_q;
    logic [Depth-1:0]    alloc_q, done_q, alloc_d, done_d;
    entry_t              slot_q [Depth];
    logic                err_q;

    logic [IdxWidth-1:0] head_idx, tail_idx;
    logic                full, issue_rdy, issue_fire, out_vld, pop, err_set;
    ptr_t                level;
    logic [Depth-1:0]    slot_we, slot_wr;
    logic [SelWidth-1:0] slot_sel [Depth];
    logic                conflict;
    logic [NumChannels-1:0] chan_bad;
    entry_t              head_entry;

    assign head_idx = head_q[IdxWidth-1:0];
    assign tail_idx = tail_q[IdxWidth-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IdxWidth] != tail_q[IdxWidth]);
    assign level    = rst_ni ? (tail_q - head_q) : '0;

    assign issue_rdy  = rst_ni && !full && !bus.flush_i;
    assign issue_fire = bus.issue_valid_i && issue_rdy;
    assign out_vld    = rst_ni && done_q[head_idx];
    assign pop        = out_vld && bus.out_ready_i && !bus.flush_i;

    fpnew_rob_wr_decode #(
        .NumChannels (NumChannels),
        .Depth       (Depth)
    ) u_wr_decode (
        .chan_valid (bus.chan_valid_i),
        .chan_id    (bus.chan_id_i),
        .slot_we    (slot_we),
        .slot_sel   (slot_sel),
        .conflict   (conflict)
    );

    // Legality uses pre-edge state, so a completion racing its own issue is rejected.
    always_comb begin
        chan_bad = '0;
        for (int c = 0; c < NumChannels; c++) begin
            chan_bad[c] = bus.chan_valid_i[c] &&
                          !(alloc_q[bus.chan_id_i[c]] && !done_q[bus.chan_id_i[c]]);
        end
    end

    assign slot_wr = slot_we & alloc_q & ~done_q;
    assign err_set = conflict || (|chan_bad);

    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q | slot_wr;
        if (issue_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
        end
        if (pop) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_q + ptr_t'(pop);
            tail_q  <= tail_q + ptr_t'(issue_fire);
            alloc_q <= alloc_d;
            done_q  <= done_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; done bits alone qualify it.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < Depth; s++) begin
            if (rst_ni && !bus.flush_i && slot_wr[s]) begin
                slot_q[s].result <= bus.chan_result_i[slot_sel[s]];
                slot_q[s].status <= bus.chan_status_i[slot_sel[s]];
                slot_q[s].tag    <= bus.chan_tag_i[slot_sel[s]];
            end
        end
    end

    assign head_entry = slot_q[head_idx];

    assign bus.issue_ready_o  = issue_rdy;
    assign bus.issue_id_o     = rst_ni ? tail_idx : '0;
    assign bus.chan_ready_o   = {NumChannels{rst_ni}};
    assign bus.out_valid_o    = out_vld;
    assign bus.result_o       = out_vld ? head_entry.result : '0;
    assign bus.status_o       = out_vld ? head_entry.status : '0;
    assign bus.tag_o          = out_vld ? head_entry.tag    : '0;
    assign bus.level_o        = level;
    assign bus.busy_o         = (level != '0);
    assign bus.protocol_err_o = err_q;
endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Directed bench for the result reorder buffer: a per-cycle vector table for in-order retirement,
// then hand-written sequences for full/wrap, same-ID conflict, stall, flush and mid-flight reset.
module tb_fpnew_result_reorder;
    import fpnew_result_reorder_pkg::*;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fpnew_result_reorder_if #(
        .NumChannels (5),
        .Width       (64),
        .Depth       (8),
        .TagType     (logic)
    ) bus ();

    fpnew_result_reorder #(
        .NumChannels (5),
        .Width       (64),
        .Depth       (8),
        .TagType     (logic)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          iv;
        int          orr;
        int          ch;
        int          id;
        int          e_ir;
        int          e_iid;
        int          e_ov;
        logic [63:0] e_res;
        int          e_lvl;
        int          e_err;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [63:0] mk_res(input int ch, input int id);
        return {16'hA5A5, 16'(ch), 16'h0000, 16'(id)};
    endfunction

    function automatic status_t mk_st(input int ch, input int id);
        return status_t'(5'(ch * 3 + id + 1));
    endfunction

    function automatic logic mk_tag(input int ch, input int id);
        return 1'(((ch >> 1) ^ id) & 1);
    endfunction

    function automatic vec_t row(input int iv, input int orr, input int ch, input int id,
                                 input int e_ir, input int e_iid, input int e_ov,
                                 input logic [63:0] e_res, input int e_lvl, input int e_err);
        vec_t v;
        v.iv = iv; v.orr = orr; v.ch = ch; v.id = id;
        v.e_ir = e_ir; v.e_iid = e_iid; v.e_ov = e_ov; v.e_res = e_res;
        v.e_lvl = e_lvl; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.issue_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.out_ready_i   = 1'b0;
        bus.chan_valid_i  = '0;
        for (int c = 0; c < 5; c++) begin
            bus.chan_id_i[c]     = '0;
            bus.chan_result_i[c] = '0;
            bus.chan_status_i[c] = '0;
            bus.chan_tag_i[c]    = 1'b0;
        end
    endtask

    task automatic set_chan(input int ch, input int id);
        bus.chan_valid_i[ch]  = 1'b1;
        bus.chan_id_i[ch]     = 3'(id);
        bus.chan_result_i[ch] = mk_res(ch, id);
        bus.chan_status_i[ch] = mk_st(ch, id);
        bus.chan_tag_i[ch]    = mk_tag(ch, id);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            clear_inputs();
            bus.issue_valid_i = 1'b1;
            advance();
        end
    endtask

    task automatic chk_head(input string name, input int ch, input int id);
        chk({name, "_ovld"},   64'(bus.out_valid_o), 64'd1);
        chk({name, "_result"}, bus.result_o,         mk_res(ch, id));
        chk({name, "_status"}, 64'(bus.status_o),    64'(mk_st(ch, id)));
        chk({name, "_tag"},    64'(bus.tag_o),       64'(mk_tag(ch, id)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = row(1, 1, -1, 0, 1, 0, 0, 64'd0,        0, 0);
        tbl[1]  = row(1, 1, -1, 0, 1, 1, 0, 64'd0,        1, 0);
        tbl[2]  = row(1, 1, -1, 0, 1, 2, 0, 64'd0,        2, 0);
        tbl[3]  = row(0, 1,  2, 2, 1, 3, 0, 64'd0,        3, 0);
        tbl[4]  = row(0, 1,  0, 0, 1, 3, 0, 64'd0,        3, 0);
        tbl[5]  = row(0, 1,  1, 1, 1, 3, 1, mk_res(0, 0), 3, 0);
        tbl[6]  = row(0, 1, -1, 0, 1, 3, 1, mk_res(1, 1), 2, 0);
        tbl[7]  = row(0, 1, -1, 0, 1, 3, 1, mk_res(2, 2), 1, 0);
        tbl[8]  = row(1, 1,  4, 3, 1, 3, 0, 64'd0,        0, 0);
        tbl[9]  = row(0, 1,  4, 3, 1, 4, 0, 64'd0,        1, 1);
        tbl[10] = row(0, 1, -1, 0, 1, 4, 1, mk_res(4, 3), 1, 1);
        tbl[11] = row(0, 1, -1, 0, 1, 4, 0, 64'd0,        0, 1);

        // Reset values while held and just after release.
        clear_inputs();
        rst_n = 1'b0;
        settle();
        chk("rst_hold_issue_ready", 64'(bus.issue_ready_o), 64'd0);
        chk("rst_hold_chan_ready",  64'(bus.chan_ready_o),  64'd0);
        chk("rst_hold_out_valid",   64'(bus.out_valid_o),   64'd0);
        chk("rst_hold_level",       64'(bus.level_o),       64'd0);
        advance();
        rst_n = 1'b1;
        settle();
        chk("rst_rel_issue_ready", 64'(bus.issue_ready_o),  64'd1);
        chk("rst_rel_chan_ready",  64'(bus.chan_ready_o),   64'h1f);
        chk("rst_rel_issue_id",    64'(bus.issue_id_o),     64'd0);
        chk("rst_rel_busy",        64'(bus.busy_o),         64'd0);
        chk("rst_rel_err",         64'(bus.protocol_err_o), 64'd0);
        advance();

        // Out-of-order completion, in-order retirement.
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            bus.issue_valid_i = 1'(tbl[i].iv);
            bus.out_ready_i   = 1'(tbl[i].orr);
            if (tbl[i].ch >= 0) set_chan(tbl[i].ch, tbl[i].id);
            settle();
            chk($sformatf("tbl%0d_issue_ready", i), 64'(bus.issue_ready_o),  64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_issue_id", i),    64'(bus.issue_id_o),     64'(tbl[i].e_iid));
            chk($sformatf("tbl%0d_out_valid", i),   64'(bus.out_valid_o),    64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_result", i),      bus.result_o,            tbl[i].e_res);
            chk($sformatf("tbl%0d_level", i),       64'(bus.level_o),        64'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_busy", i),        64'(bus.busy_o),         64'(tbl[i].e_lvl != 0));
            chk($sformatf("tbl%0d_err", i),         64'(bus.protocol_err_o), 64'(tbl[i].e_err));
            advance();
        end

        // Fill to Depth, then a pop does not free a slot for issue in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.issue_valid_i = 1'b1;
            settle();
            chk($sformatf("fill%0d_issue_id", i), 64'(bus.issue_id_o), 64'(i));
            advance();
        end
        clear_inputs();
        bus.issue_valid_i = 1'b1;
        set_chan(0, 0);
        settle();
        chk("full_issue_ready", 64'(bus.issue_ready_o), 64'd0);
        chk("full_level",       64'(bus.level_o),       64'd8);
        advance();
        clear_inputs();
        bus.issue_valid_i = 1'b1;
        bus.out_ready_i   = 1'b1;
        settle();
        chk_head("full_pop", 0, 0);
        chk("full_pop_issue_ready", 64'(bus.issue_ready_o), 64'd0);
        chk("full_pop_level",       64'(bus.level_o),       64'd8);
        chk("full_pop_issue_id",    64'(bus.issue_id_o),    64'd0);
        advance();
        clear_inputs();
        bus.issue_valid_i = 1'b1;
        settle();
        chk("wrap_issue_ready", 64'(bus.issue_ready_o), 64'd1);
        chk("wrap_issue_id",    64'(bus.issue_id_o),    64'd0);
        chk("wrap_level",       64'(bus.level_o),       64'd7);
        advance();
        clear_inputs();
        settle();
        chk("wrap_after_level",  64'(bus.level_o),       64'd8);
        chk("wrap_after_ready",  64'(bus.issue_ready_o), 64'd0);
        chk("wrap_after_id",     64'(bus.issue_id_o),    64'd1);
        chk("wrap_after_ovld",   64'(bus.out_valid_o),   64'd0);

        // Two channels on one ID: lowest channel wins, error is sticky.
        do_reset();
        issue_n(5);
        clear_inputs();
        set_chan(1, 4);
        set_chan(3, 4);
        settle();
        chk("dup_err_before", 64'(bus.protocol_err_o), 64'd0);
        advance();
        clear_inputs();
        set_chan(0, 0);
        set_chan(2, 1);
        set_chan(4, 2);
        settle();
        chk("dup_err_after", 64'(bus.protocol_err_o), 64'd1);
        chk("dup_ovld_idle", 64'(bus.out_valid_o),    64'd0);
        advance();
        clear_inputs();
        set_chan(0, 3);
        settle();
        chk_head("dup_hold0", 0, 0);
        advance();
        begin
            int exp_ch [5] = '{0, 2, 4, 0, 1};
            for (int k = 0; k < 5; k++) begin
                clear_inputs();
                bus.out_ready_i = 1'b1;
                settle();
                chk_head($sformatf("dup_pop%0d", k), exp_ch[k], k);
                advance();
            end
        end
        clear_inputs();
        set_chan(2, 7);
        settle();
        chk("unalloc_level", 64'(bus.level_o),       64'd0);
        advance();
        clear_inputs();
        settle();
        chk("unalloc_ovld", 64'(bus.out_valid_o),    64'd0);
        chk("unalloc_err",  64'(bus.protocol_err_o), 64'd1);

        // Downstream stall holds the head stable.
        do_reset();
        issue_n(1);
        clear_inputs();
        set_chan(3, 0);
        advance();
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            settle();
            chk_head($sformatf("stall%0d", k), 3, 0);
            chk($sformatf("stall%0d_level", k), 64'(bus.level_o), 64'd1);
            advance();
        end
        clear_inputs();
        bus.out_ready_i = 1'b1;
        settle();
        chk_head("stall_release", 3, 0);
        advance();
        clear_inputs();
        settle();
        chk("stall_done_ovld",  64'(bus.out_valid_o), 64'd0);
        chk("stall_done_level", 64'(bus.level_o),     64'd0);

        // Flush beats issue, completion and pop in the same cycle.
        do_reset();
        issue_n(5);
        clear_inputs();
        set_chan(0, 1);
        set_chan(1, 3);
        set_chan(2, 6);
        advance();
        clear_inputs();
        bus.flush_i       = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.out_ready_i   = 1'b1;
        set_chan(0, 2);
        settle();
        chk("flush_issue_ready", 64'(bus.issue_ready_o),  64'd0);
        chk("flush_pre_level",   64'(bus.level_o),        64'd5);
        chk("flush_pre_err",     64'(bus.protocol_err_o), 64'd1);
        advance();
        clear_inputs();
        settle();
        chk("flush_level",    64'(bus.level_o),        64'd0);
        chk("flush_ovld",     64'(bus.out_valid_o),    64'd0);
        chk("flush_busy",     64'(bus.busy_o),         64'd0);
        chk("flush_err",      64'(bus.protocol_err_o), 64'd0);
        chk("flush_issue_id", 64'(bus.issue_id_o),     64'd0);
        advance();

        // Reset with entries in flight discards them.
        do_reset();
        issue_n(4);
        clear_inputs();
        set_chan(4, 0);
        advance();
        clear_inputs();
        settle();
        chk_head("prerst", 4, 0);
        chk("prerst_level", 64'(bus.level_o), 64'd4);
        advance();
        rst_n = 1'b0;
        settle();
        chk("midrst_issue_ready", 64'(bus.issue_ready_o), 64'd0);
        chk("midrst_chan_ready",  64'(bus.chan_ready_o),  64'd0);
        chk("midrst_ovld",        64'(bus.out_valid_o),   64'd0);
        chk("midrst_level",       64'(bus.level_o),       64'd0);
        advance();
        rst_n = 1'b1;
        bus.issue_valid_i = 1'b1;
        settle();
        chk("postrst_issue_ready", 64'(bus.issue_ready_o),  64'd1);
        chk("postrst_chan_ready",  64'(bus.chan_ready_o),   64'h1f);
        chk("postrst_ovld",        64'(bus.out_valid_o),    64'd0);
        chk("postrst_level",       64'(bus.level_o),        64'd0);
        chk("postrst_issue_id",    64'(bus.issue_id_o),     64'd0);
        chk("postrst_err",         64'(bus.protocol_err_o), 64'd0);
        advance();
        clear_inputs();
        settle();
        chk("postrst_issued_level", 64'(bus.level_o),    64'd1);
        chk("postrst_next_id",      64'(bus.issue_id_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
